// File: rtl/bd_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bd_tx_fifo
// Description : Clocked source stage for a 4-phase bundled-data shim.
//               A DEPTH-entry FIFO is written by synchronous logic. An FSM
//               drains it one word at a time over a return-to-zero req/ack
//               handshake (aReq/aAck/a).
// Config macro: ACK_SYNC_EN - when defined, aAck passes through a 2-flop
//               synchroniser. When undefined, aAck is sampled directly,
//               which is only suitable for same-domain simulation.
// Revision    : 1.0 - initial release
// ============================================================================
module bd_tx_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active-low
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             aReq,
  input  logic             aAck,
  output logic [WIDTH-1:0] a,
  output logic             busy
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               areq_q, areq_d;
  logic               push, pop;
  logic               ack_s;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign aReq     = areq_q;
  assign a        = a_q;
  assign busy     = (state_q != IDLE);

  // A full FIFO rejects writes even when a pop happens on the same edge.
  assign push = wr_en && !full;

`ifdef ACK_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser bringing the asynchronous acknowledge into clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= aAck;
      sync2_q <= sync1_q;
    end
  end

  assign ack_s = sync2_q;
`else
  // Same-clock-domain shim: acknowledge used as-is at each edge.
  assign ack_s = aAck;
`endif

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Occupancy bookkeeping: a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM next-state logic; data is loaded one cycle before aReq rises.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    areq_d  = areq_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = mem_q[rptr_q];
          state_d = SETUP;
        end
      end
      SETUP: begin
        areq_d  = 1'b1;
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          areq_d  = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointers, count, sticky overflow and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      a_q        <= '0;
      areq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      areq_q  <= areq_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bd_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bd_tx_fifo
// Description : Self-checking bench for bd_tx_fifo with a behavioural
//               4-phase shim and a scoreboard of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bd_tx_fifo;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef ACK_SYNC_EN
  localparam int PERIOD = 8;
`else
  localparam int PERIOD = 4;
`endif

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             aReq;
  logic             aAck;
  logic [WIDTH-1:0] a;
  logic             busy;

  int               errors = 0;
  int               checks = 0;
  int               rx_count = 0;
  int               cyc = 0;
  bit               stall = 0;
  logic [WIDTH-1:0] sb[$];
  int               rise_q[$];

  bd_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .aReq     (aReq),
    .aAck     (aAck),
    .a        (a),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shim: acks 2 ns after each req edge unless stalled.
  initial begin
    aAck = 1'b0;
    forever begin
      wait (aReq === 1'b1 && !stall);
      #2 aAck = 1'b1;
      wait (aReq === 1'b0);
      #2 aAck = 1'b0;
    end
  end

  // Receiver side of the scoreboard: every request must carry the next word.
  always @(posedge aReq) begin
    logic [WIDTH-1:0] exp;
    rx_count++;
    rise_q.push_back(cyc);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL rx_unexpected: a=%0d, required no word", a);
    end else begin
      exp = sb.pop_front();
      if (a !== exp) begin
        errors++;
        $display("FAIL rx_data: a=%0d, required %0d", a, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_data = d;
    wr_en   = 1'b1;
    if (!full) sb.push_back(d);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!(empty && !busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(empty && !busy)) begin
      errors++;
      $display("FAIL drain_timeout: empty=%0b busy=%0b, required empty=1 busy=0", empty, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: %0b, required 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: %0b, required 0", full); end
    checks++; if (count !== '0)      begin errors++; $display("FAIL reset_count: %0d, required 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: %0b, required 0", overflow); end
    checks++; if (aReq !== 1'b0)     begin errors++; $display("FAIL reset_aReq: %0b, required 0", aReq); end
    checks++; if (a !== '0)          begin errors++; $display("FAIL reset_a: %0d, required 0", a); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: %0b, required 0", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int rx0 = rx_count;
    write_word(12'd14);                        // edge k
    checks++; if (aReq !== 1'b0) begin errors++; $display("FAIL lat_k_aReq: %0b, required 0", aReq); end
    @(posedge clk); #1;                        // edge k+1
    checks++; if (a !== 12'd14)  begin errors++; $display("FAIL lat_k1_a: %0d, required 14", a); end
    checks++; if (aReq !== 1'b0) begin errors++; $display("FAIL lat_k1_aReq: %0b, required 0", aReq); end
    @(posedge clk); #1;                        // edge k+2
    checks++; if (aReq !== 1'b1) begin errors++; $display("FAIL lat_k2_aReq: %0b, required 1", aReq); end
    wait_drain(100);
    checks++; if (rx_count - rx0 !== 1) begin errors++; $display("FAIL lat_rx_count: %0d, required 1", rx_count - rx0); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_empty: %0b, required 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] data [7];
    bit saw_full = 0;
    int rx0 = rx_count;
    int d12;
    data = '{12'd14, 12'd5, 12'd118, 12'd51, 12'd27, 12'd8, 12'd77};
    rise_q.delete();
    for (int i = 0; i < 7; i++) begin
      int n = 0;
      @(negedge clk);
      while (full && n < 200) begin
        saw_full = 1;
        @(negedge clk);
        n++;
      end
      wr_data = data[i];
      wr_en   = 1'b1;
      sb.push_back(data[i]);
      @(posedge clk);
      #1 wr_en = 1'b0;
    end
    wait_drain(400);
    checks++; if (rx_count - rx0 !== 7) begin errors++; $display("FAIL b2b_rx_count: %0d, required 7", rx_count - rx0); end
    checks++; if (saw_full !== 1'b1)    begin errors++; $display("FAIL b2b_full_seen: %0b, required 1", saw_full); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL b2b_overflow: %0b, required 0", overflow); end
    checks++; if (sb.size() !== 0)      begin errors++; $display("FAIL b2b_sb_left: %0d, required 0", sb.size()); end
    d12 = (rise_q.size() >= 3) ? rise_q[2] - rise_q[1] : -1;
    checks++; if (d12 !== PERIOD)       begin errors++; $display("FAIL b2b_period: %0d cycles, required %0d", d12, PERIOD); end
  endtask

  task automatic test_overflow();
    int rx0 = rx_count;
    stall = 1;
    write_word(12'd101);
    write_word(12'd102);
    write_word(12'd103);
    write_word(12'd104);
    @(negedge clk);
    checks++; if (count !== 3)       begin errors++; $display("FAIL ovf_count_after_pop: %0d, required 3", count); end
    write_word(12'd105);
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: %0b, required 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: %0b, required 0", overflow); end
    write_word(12'd999);             // dropped: FIFO full
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: %0b, required 1", overflow); end
    checks++; if (count !== 4)       begin errors++; $display("FAIL ovf_count: %0d, required 4", count); end
    @(negedge clk);
    stall = 0;
    wait_drain(400);
    checks++; if (rx_count - rx0 !== 5) begin errors++; $display("FAIL ovf_rx_count: %0d, required 5", rx_count - rx0); end
    checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_hold: %0b, required 1", overflow); end
  endtask

  task automatic test_simultaneous();
    int rx0 = rx_count;
    int n = 0;
    stall = 1;
    write_word(12'd201);
    write_word(12'd202);
    write_word(12'd203);
    @(negedge clk);
    checks++; if (count !== 2) begin errors++; $display("FAIL sim_pre_count: %0d, required 2", count); end
    stall = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    // FSM is idle with data waiting: the next edge pops while we write.
    wr_data = 12'd204;
    wr_en   = 1'b1;
    if (!full) sb.push_back(12'd204);
    @(posedge clk);
    #1 wr_en = 1'b0;
    checks++; if (count !== 2)   begin errors++; $display("FAIL sim_count: %0d, required 2", count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sim_popped: busy=%0b, required 1", busy); end
    wait_drain(400);
    checks++; if (rx_count - rx0 !== 4) begin errors++; $display("FAIL sim_rx_count: %0d, required 4", rx_count - rx0); end
  endtask

  task automatic test_reset_mid_handshake();
    int rx0;
    int n = 0;
    stall = 1;
    write_word(12'd301);
    write_word(12'd302);
    @(negedge clk);
    while (aReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (aReq !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: aReq=%0b, required 1", aReq); end
    reset = 1'b0;
    #1;
    checks++; if (aReq !== 1'b0) begin errors++; $display("FAIL rst_mid_aReq: %0b, required 0", aReq); end
    checks++; if (a !== '0)      begin errors++; $display("FAIL rst_mid_a: %0d, required 0", a); end
    checks++; if (count !== '0)  begin errors++; $display("FAIL rst_mid_count: %0d, required 0", count); end
    sb.delete();
    rx0 = rx_count;
    @(negedge clk);
    reset = 1'b1;
    stall = 0;
    repeat (20) @(negedge clk);
    checks++; if (rx_count !== rx0) begin errors++; $display("FAIL rst_stale_word: %0d words sent, required 0", rx_count - rx0); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL rst_empty: %0b, required 1", empty); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
